// File: rtl/sram_controller.sv
// MEM-stage data responder: splits each 32-bit access into two 16-bit SRAM
// accesses of PHASE_CYCLES cycles each, holding ready low until completion.
//
// state | meaning
// IDLE  | waiting for a request; captures address, data and op
// LOW   | accessing the low halfword {word,0}
// HIGH  | accessing the high halfword {word,1}
// DONE  | completion cycle, ready high; held requests are ignored
module sram_controller #(
    parameter int BASE_ADDR    = 1024,
    parameter int SRAM_ADDR_W  = 18,
    parameter int PHASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            alu_res_in,
    input  logic [31:0]            val_rm_in,
    input  logic                   mem_write_enable_in,
    input  logic                   mem_read_enable_in,
    output logic [31:0]            read_data_out,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_we_n
);

    localparam int CNT_W  = $clog2(PHASE_CYCLES + 1);
    localparam int WORD_W = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  word_in, word_q;
    logic [15:0]        wval_hi_q;
    logic [15:0]        low_q;
    logic               is_write_q;
    logic               req;
    logic               phase_end;

    assign req       = mem_write_enable_in | mem_read_enable_in;
    assign phase_end = (cnt == CNT_W'(PHASE_CYCLES - 1));
    // Out-of-range addresses simply wrap by truncation.
    assign word_in   = WORD_W'((alu_res_in - 32'(BASE_ADDR)) >> 2);
    assign ready     = ((state == IDLE) && !req) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = LOW;
            LOW:     if (phase_end) state_next = HIGH;
            HIGH:    if (phase_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (((state == LOW) || (state == HIGH)) && !phase_end)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end

    // SRAM pins are registered so they hold their last values outside LOW/HIGH.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q        <= '0;
            wval_hi_q     <= '0;
            is_write_q    <= 1'b0;
            low_q         <= '0;
            read_data_out <= '0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_we_n     <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    word_q     <= word_in;
                    wval_hi_q  <= val_rm_in[31:16];
                    is_write_q <= mem_write_enable_in;
                    sram_addr  <= {word_in, 1'b0};
                    sram_we_n  <= ~mem_write_enable_in;
                    if (mem_write_enable_in) sram_wdata <= val_rm_in[15:0];
                end
                LOW: if (phase_end) begin
                    sram_addr <= {word_q, 1'b1};
                    if (is_write_q) sram_wdata <= wval_hi_q;
                    else            low_q      <= sram_rdata;
                end
                HIGH: if (phase_end) begin
                    sram_we_n <= 1'b1;
                    if (!is_write_q) read_data_out <= {sram_rdata, low_q};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model that commits a
// write only after the strobe has been held at one address for P cycles.
module tb_sram_controller;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic        mem_write_enable_in;
    logic        mem_read_enable_in;
    logic [31:0] read_data_out;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:63];
    int          wr_cnt = 0;
    logic [17:0] wr_addr = '0;

    sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .PHASE_CYCLES(P)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alu_res_in          (alu_res_in),
        .val_rm_in           (val_rm_in),
        .mem_write_enable_in (mem_write_enable_in),
        .mem_read_enable_in  (mem_read_enable_in),
        .read_data_out       (read_data_out),
        .ready               (ready),
        .sram_addr           (sram_addr),
        .sram_wdata          (sram_wdata),
        .sram_rdata          (sram_rdata),
        .sram_we_n           (sram_we_n)
    );

    always #5 clk = ~clk;

    // Fixed read contents for the read tests; other halfwords read back writes.
    always_comb begin
        case (sram_addr[5:0])
            6'd4:    sram_rdata = 16'h1234;
            6'd5:    sram_rdata = 16'hABCD;
            6'd8:    sram_rdata = 16'h1111;
            6'd9:    sram_rdata = 16'h2222;
            6'd10:   sram_rdata = 16'h0F0F;
            6'd11:   sram_rdata = 16'hF0F0;
            default: sram_rdata = mem[sram_addr[5:0]];
        endcase
    end

    always @(posedge clk) begin
        if (!sram_we_n) begin
            if (wr_cnt != 0 && sram_addr == wr_addr) wr_cnt = wr_cnt + 1;
            else                                     wr_cnt = 1;
            wr_addr = sram_addr;
            if (wr_cnt == P) mem[sram_addr[5:0]] <= sram_wdata;
        end else begin
            wr_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_write_enable_in = 1'b0;
        mem_read_enable_in  = 1'b0;
        alu_res_in          = 32'h0000_3000;
        val_rm_in           = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset();
        // Reset asserted together with a write request: reset must win.
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        mem_write_enable_in = 1'b1;
        alu_res_in          = 32'd1024;
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks += 5;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
        if (read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", read_data_out); end
        if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
        if (sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", sram_wdata); end
    endtask

    task automatic test_write();
        logic        exp_ready, exp_we_n;
        logic [17:0] exp_addr;
        logic [15:0] exp_wd;
        step();
        mem_write_enable_in = 1'b1;
        alu_res_in          = 32'd1024;
        val_rm_in           = 32'hDEADBEEF;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) idle_inputs();
            end
            @(negedge clk);
            exp_ready = (c >= 2*P+1);
            exp_we_n  = !(c >= 1 && c <= 2*P);
            exp_addr  = (c <= P) ? 18'd0 : 18'd1;
            exp_wd    = (c <= P) ? 16'hBEEF : 16'hDEAD;
            checks += 2;
            if (ready !== exp_ready) begin errors++; $display("FAIL wr_ready c=%0d got %b want %b", c, ready, exp_ready); end
            if (sram_we_n !== exp_we_n) begin errors++; $display("FAIL wr_we_n c=%0d got %b want %b", c, sram_we_n, exp_we_n); end
            if (c >= 1 && c <= 2*P) begin
                checks += 2;
                if (sram_addr !== exp_addr) begin errors++; $display("FAIL wr_addr c=%0d got %h want %h", c, sram_addr, exp_addr); end
                if (sram_wdata !== exp_wd) begin errors++; $display("FAIL wr_wdata c=%0d got %h want %h", c, sram_wdata, exp_wd); end
            end
        end
        checks += 2;
        if (mem[0] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem0 got %h want beef", mem[0]); end
        if (mem[1] !== 16'hDEAD) begin errors++; $display("FAIL wr_mem1 got %h want dead", mem[1]); end
    endtask

    task automatic test_read();
        logic [31:0] exp_rd;
        logic [17:0] exp_addr;
        step();
        mem_read_enable_in = 1'b1;
        alu_res_in         = 32'd1032;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) idle_inputs();
            end
            @(negedge clk);
            exp_rd   = (c >= 2*P+1) ? 32'hABCD1234 : 32'h0;
            exp_addr = (c <= P) ? 18'd4 : 18'd5;
            checks += 3;
            if (read_data_out !== exp_rd) begin errors++; $display("FAIL rd_data c=%0d got %h want %h", c, read_data_out, exp_rd); end
            if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rd_we_n c=%0d got %b want 1", c, sram_we_n); end
            if (ready !== (c >= 2*P+1)) begin errors++; $display("FAIL rd_ready c=%0d got %b", c, ready); end
            if (c >= 1 && c <= 2*P) begin
                checks++;
                if (sram_addr !== exp_addr) begin errors++; $display("FAIL rd_addr c=%0d got %h want %h", c, sram_addr, exp_addr); end
            end
        end
    endtask

    task automatic test_read_write_both();
        step();
        mem_read_enable_in  = 1'b1;
        mem_write_enable_in = 1'b1;
        alu_res_in          = 32'd1028;
        val_rm_in           = 32'h55AA1357;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) idle_inputs();
            end
            @(negedge clk);
            if (c == 1) begin
                checks += 2;
                if (sram_we_n !== 1'b0) begin errors++; $display("FAIL both_we_n got %b want 0", sram_we_n); end
                if (sram_addr !== 18'd2) begin errors++; $display("FAIL both_addr got %h want 2", sram_addr); end
            end
        end
        checks += 3;
        if (mem[2] !== 16'h1357) begin errors++; $display("FAIL both_mem2 got %h want 1357", mem[2]); end
        if (mem[3] !== 16'h55AA) begin errors++; $display("FAIL both_mem3 got %h want 55aa", mem[3]); end
        if (read_data_out !== 32'hABCD1234) begin errors++; $display("FAIL both_rdata got %h want abcd1234", read_data_out); end
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        step();
        mem_read_enable_in = 1'b1;
        alu_res_in         = 32'd1040;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                step();
                if (c == 6) alu_res_in = 32'd1044;
                if (c == 7) idle_inputs();
            end
            @(negedge clk);
            exp_ready = (c == 5) || (c >= 11);
            checks++;
            if (ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c=%0d got %b want %b", c, ready, exp_ready); end
            if (c == 5) begin
                checks++;
                if (read_data_out !== 32'h22221111) begin errors++; $display("FAIL b2b_rd1 got %h want 22221111", read_data_out); end
            end
            if (c == 6) begin
                checks++;
                if (sram_addr !== 18'd9) begin errors++; $display("FAIL b2b_hold_addr got %h want 9", sram_addr); end
            end
            if (c == 7 || c == 9) begin
                checks++;
                if (sram_addr !== ((c == 7) ? 18'd10 : 18'd11)) begin errors++; $display("FAIL b2b_addr c=%0d got %h", c, sram_addr); end
            end
            if (c == 11) begin
                checks++;
                if (read_data_out !== 32'hF0F00F0F) begin errors++; $display("FAIL b2b_rd2 got %h want f0f00f0f", read_data_out); end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        step();
        mem_write_enable_in = 1'b1;
        alu_res_in          = 32'd1024;
        val_rm_in           = 32'hCAFEF00D;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) idle_inputs();
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
        end
        @(negedge clk);
        checks += 6;
        if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
        if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_we_n got %b want 1", sram_we_n); end
        if (read_data_out !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", read_data_out); end
        if (sram_addr !== 18'h0) begin errors++; $display("FAIL rstmid_addr got %h want 0", sram_addr); end
        if (mem[0] !== 16'hF00D) begin errors++; $display("FAIL rstmid_mem0 got %h want f00d", mem[0]); end
        if (mem[1] !== 16'hDEAD) begin errors++; $display("FAIL rstmid_mem1 got %h want dead", mem[1]); end
        step();
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_idle_we_n got %b want 1", sram_we_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
